// File: rtl/aes_block_loader_if.sv
// Signal bundle between aes_block_loader and its neighbours: plaintext word stream, key, AES core drive, ciphertext handshake.
// slave = the loader itself; master = upstream/downstream logic and the cipher core.
interface aes_block_loader_if #(
  parameter int NK = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [NK*32-1:0] key_in;
  logic             cipher_reset;
  logic             cipher_enable;
  logic [127:0]     cipher_state_in;
  logic [NK*32-1:0] cipher_key;
  logic [127:0]     cipher_state_out;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, key_in, cipher_state_out, out_ready,
    output in_ready, cipher_reset, cipher_enable, cipher_state_in, cipher_key,
           out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, key_in, cipher_state_out, out_ready,
    input  in_ready, cipher_reset, cipher_enable, cipher_state_in, cipher_key,
           out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_block_loader.sv
// Packs 4 plaintext words + key, runs the AES core for RUN_CYCLES, registers ciphertext (out_valid at 4th-word edge + RUN_CYCLES + 2).
// out_ready low stalls in DONE indefinitely; AES_LOADER_PREFETCH_EN adds a second block/key buffer so the next block fills meanwhile.
module aes_block_loader #(
  parameter int NK = 4
) (
  input logic               clk,
  input logic               reset,
  aes_block_loader_if.slave bus
);
  localparam int RUN_CYCLES = (NK + 7) * 4 + 4;
  localparam int RW         = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {FILL, CLEAR, RUN, CAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [127:0]     blk_q, blk_d;
  logic [NK*32-1:0] key_q, key_d;
  logic [RW-1:0]    run_q, run_d;
  logic [127:0]     out_data_q, out_data_d;
  logic             in_ready_q, in_ready_d;
  logic             cipher_reset_q, cipher_reset_d;
  logic             cipher_enable_q, cipher_enable_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             accept, last, hs;

`ifdef AES_LOADER_PREFETCH_EN
  // Words always assemble in fill_q; blk_q/key_q only change when a block launches.
  logic [127:0]     fill_q, fill_d;
  logic [NK*32-1:0] pkey_q, pkey_d;
  logic             pend_q, pend_d;
`endif

  assign accept = bus.in_valid && in_ready_q;
  assign last   = accept && (cnt_q == 2'd3);
  assign hs     = (state_q == DONE) && out_valid_q && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    key_d      = key_q;
    run_d      = run_q;
    out_data_d = out_data_q;
`ifdef AES_LOADER_PREFETCH_EN
    fill_d     = fill_q;
    pkey_d     = pkey_q;
    pend_d     = pend_q;
    if (accept) begin
      fill_d = {fill_q[95:0], bus.in_data};
      cnt_d  = cnt_q + 2'd1;
    end
`else
    if (accept) begin
      blk_d = {blk_q[95:0], bus.in_data};
      cnt_d = cnt_q + 2'd1;
      if (last) key_d = bus.key_in;
    end
`endif

    case (state_q)
      FILL:  if (last) state_d = CLEAR;
      CLEAR: begin
        state_d = RUN;
        run_d   = RW'(RUN_CYCLES);
      end
      RUN: begin
        run_d = run_q - RW'(1);
        if (run_q == RW'(1)) state_d = CAP;
      end
      CAP: begin
        out_data_d = bus.cipher_state_out;
        state_d    = DONE;
      end
      DONE:    if (hs) state_d = FILL;
      default: state_d = FILL;
    endcase

`ifdef AES_LOADER_PREFETCH_EN
    // A buffered block launches on the handshake; a block completing in FILL or on the handshake launches directly.
    if (hs && pend_q) begin
      blk_d   = fill_q;
      key_d   = pkey_q;
      pend_d  = 1'b0;
      state_d = CLEAR;
    end else if (last && ((state_q == FILL) || hs)) begin
      blk_d   = fill_d;
      key_d   = bus.key_in;
      state_d = CLEAR;
    end else if (last) begin
      pkey_d = bus.key_in;
      pend_d = 1'b1;
    end
    in_ready_d = !pend_d;
`else
    in_ready_d = (state_d == FILL);
`endif

    cipher_reset_d  = (state_d == CLEAR);
    cipher_enable_d = (state_d == RUN);
    out_valid_d     = (state_d == DONE);
    busy_d          = (state_d != FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= FILL;
      cnt_q           <= 2'd0;
      blk_q           <= '0;
      key_q           <= '0;
      run_q           <= '0;
      out_data_q      <= '0;
      in_ready_q      <= 1'b1;
      cipher_reset_q  <= 1'b1;
      cipher_enable_q <= 1'b0;
      out_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
`ifdef AES_LOADER_PREFETCH_EN
      fill_q          <= '0;
      pkey_q          <= '0;
      pend_q          <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      blk_q           <= blk_d;
      key_q           <= key_d;
      run_q           <= run_d;
      out_data_q      <= out_data_d;
      in_ready_q      <= in_ready_d;
      cipher_reset_q  <= cipher_reset_d;
      cipher_enable_q <= cipher_enable_d;
      out_valid_q     <= out_valid_d;
      busy_q          <= busy_d;
`ifdef AES_LOADER_PREFETCH_EN
      fill_q          <= fill_d;
      pkey_q          <= pkey_d;
      pend_q          <= pend_d;
`endif
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.cipher_reset    = cipher_reset_q;
  assign bus.cipher_enable   = cipher_enable_q;
  assign bus.cipher_state_in = blk_q;
  assign bus.cipher_key      = key_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.busy            = busy_q;
endmodule
